// File: rtl/pal_frame_tx.sv
// Frame transmitter for the pipe_pal byte link: buffers a burst of words, then
// emits SOF, LEN, payload (MSB byte first) and a zero-sum checksum byte.
module pal_frame_tx #(
  parameter int          W_DATA  = 32,
  parameter int          MAX_LEN = 16,
  parameter logic [7:0]  SOF     = 8'hA5
) (
  input  logic              i_clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W_DATA-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_byte,
  output logic              m_last,
  output logic              o_trunc
);

  localparam int B  = W_DATA / 8;
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_LEN - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(B - 1);

  typedef enum logic [2:0] {
    COLLECT, SEND_SOF, SEND_LEN, SEND_DATA, SEND_CSUM
  } state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [AW-1:0]     word_idx;
  logic [BW-1:0]     byte_idx;
  logic [7:0]        csum;
  logic [W_DATA-1:0] buffer [MAX_LEN];
  logic [W_DATA-1:0] shifted;
  logic              s_hs;
  logic              m_hs;

  // Handshake qualifiers depend only on the state register, never on the peer's valid/ready.
  assign s_ready = (state == COLLECT);
  assign m_valid = (state != COLLECT);
  assign m_last  = (state == SEND_CSUM);
  assign s_hs    = s_valid && s_ready;
  assign m_hs    = m_valid && m_ready;

  assign shifted = buffer[word_idx] << {byte_idx, 3'b000};

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    m_byte = 8'h00;
    unique case (state)
      SEND_SOF:  m_byte = SOF;
      SEND_LEN:  m_byte = 8'(count);
      SEND_DATA: m_byte = shifted[W_DATA-1 -: 8];
      SEND_CSUM: m_byte = 8'h00 - csum;
      default:   m_byte = 8'h00;
    endcase
  end

  // NOTE: the payload buffer is storage only; it is never read before being written, so it has no reset.
  always_ff @(posedge i_clk) begin
    if (s_hs) buffer[count[AW-1:0]] <= s_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      state    <= COLLECT;
      count    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      csum     <= '0;
      o_trunc  <= 1'b0;
    end else begin
      o_trunc <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (s_hs) begin
            count <= count + CW'(1);
            if (s_last || count == CNT_LAST) state <= SEND_SOF;
            o_trunc <= !s_last && (count == CNT_LAST);
          end
        end
        SEND_SOF: begin
          if (m_hs) state <= SEND_LEN;
        end
        SEND_LEN: begin
          if (m_hs) begin
            csum     <= csum + m_byte;
            word_idx <= '0;
            byte_idx <= '0;
            state    <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (m_hs) begin
            csum <= csum + m_byte;
            if (byte_idx == BYTE_LAST) begin
              byte_idx <= '0;
              if (CW'(word_idx) == count - CW'(1)) begin
                word_idx <= '0;
                state    <= SEND_CSUM;
              end else begin
                word_idx <= word_idx + AW'(1);
              end
            end else begin
              byte_idx <= byte_idx + BW'(1);
            end
          end
        end
        SEND_CSUM: begin
          if (m_hs) begin
            count <= '0;
            csum  <= '0;
            state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_pal_frame_tx.sv
// Self-checking bench for pal_frame_tx: table vectors, hand-written corner
// sequences and random frames compared against a byte-level frame model.
module tb_pal_frame_tx;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic        m_valid, m_ready, m_last, o_trunc;
  logic [7:0]  m_byte;

  int tests = 0;
  int fails = 0;
  int up_hs = 0;
  int tx_sready = 0;
  int trunc_cnt = 0;
  int trunc_bad = 0;

  pal_frame_tx #(.W_DATA(32), .MAX_LEN(16), .SOF(8'hA5)) dut (
    .i_clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_byte(m_byte), .m_last(m_last),
    .o_trunc(o_trunc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (resetn && o_trunc) begin
      trunc_cnt++;
      if (!(m_valid && m_byte == 8'hA5)) trunc_bad++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame built directly from the framing rules.
  function automatic void build_frame(input logic [31:0] w[$], output logic [7:0] f[$]);
    int sum;
    f = {};
    f.push_back(8'hA5);
    f.push_back(8'(w.size()));
    sum = w.size();
    foreach (w[i]) begin
      for (int k = 3; k >= 0; k--) begin
        f.push_back(w[i][8*k +: 8]);
        sum += int'(w[i][8*k +: 8]);
      end
    end
    f.push_back(8'((256 - (sum % 256)) % 256));
  endfunction

  task automatic compare_frame(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
    check({name, "_size"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check({name, "_byte"}, 64'(got[i]), 64'(exp[i]));
  endtask

  task automatic push_word(input logic [31:0] d, input bit l);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("push_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [31:0] w[$], input bit gaps);
    for (int i = 0; i < w.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          @(negedge clk);
        end
      end
      push_word(w[i], i == w.size() - 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic recv(input bit rnd, output logic [7:0] q[$], output int cyc);
    bit         done = 1'b0, pstall = 1'b0;
    logic [7:0] pb = 8'h00;
    logic       pl = 1'b0;
    int         n = 0;
    q = {};
    cyc = 0;
    while (!done && n < 3000) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pstall) check("hold_stable", {54'd0, m_valid, m_last, m_byte}, {54'd0, 1'b1, pl, pb});
      if (m_valid) begin
        cyc++;
        if (s_ready) tx_sready++;
      end
      if (s_valid && s_ready) up_hs++;
      if (m_valid && m_ready) begin
        q.push_back(m_byte);
        done = m_last;
      end
      pstall = m_valid && !m_ready;
      pb = m_byte;
      pl = m_last;
      @(negedge clk);
      n++;
    end
    m_ready = 1'b0;
    if (!done) check("recv_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    int          nw;
    logic [31:0] w [3];
    logic [7:0]  len;
    logic [7:0]  csum;
  } vec_t;

  vec_t        vecs [3];
  logic [31:0] wq[$], wq2[$];
  logic [7:0]  got[$], got2[$], exp[$];
  int          cyc, cyc2;

  initial begin
    vecs[0].nw = 1; vecs[0].w = '{32'h01020304, 32'h0, 32'h0};
    vecs[0].len = 8'h01; vecs[0].csum = 8'hF5;
    vecs[1].nw = 3; vecs[1].w = '{32'hFFFFFFFF, 32'h00000000, 32'h80000001};
    vecs[1].len = 8'h03; vecs[1].csum = 8'h80;
    vecs[2].nw = 2; vecs[2].w = '{32'h12345678, 32'h9ABCDEF0, 32'h0};
    vecs[2].len = 8'h02; vecs[2].csum = 8'hC6;

    resetn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_byte",  64'(m_byte),  64'd0);
    check("rst_m_last",  64'(m_last),  64'd0);
    check("rst_o_trunc", 64'(o_trunc), 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Table vectors, first with m_ready held high, then with random back-pressure.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) begin
        wq = {};
        for (int j = 0; j < vecs[i].nw; j++) wq.push_back(vecs[i].w[j]);
        push_frame(wq, 1'b0);
        check("sof_latency", {55'd0, m_valid, m_byte}, {55'd0, 1'b1, 8'hA5});
        tx_sready = 0;
        recv(pass == 1, got, cyc);
        check("tx_s_ready_low", 64'(tx_sready), 64'd0);
        check("tbl_len", 64'(got[1]), 64'(vecs[i].len));
        check("tbl_csum", 64'(got[got.size()-1]), 64'(vecs[i].csum));
        build_frame(wq, exp);
        compare_frame("tbl_frame", got, exp);
        if (pass == 0) check("frame_cycles", 64'(cyc), 64'(3 + vecs[i].nw * 4));
      end
    end

    // 20 words with s_last only on the last: a truncated 16-word frame then a 4-word frame.
    wq = {};
    for (int i = 0; i < 20; i++) wq.push_back($urandom);
    trunc_cnt = 0; trunc_bad = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) push_word(wq[i], i == 19);
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      begin
        recv(1'b0, got, cyc);
        recv(1'b0, got2, cyc2);
      end
    join
    wq2 = wq[0:15];
    build_frame(wq2, exp);
    compare_frame("trunc_frame1", got, exp);
    check("trunc_len1", 64'(got[1]), 64'd16);
    check("trunc_cycles1", 64'(cyc), 64'(3 + 16 * 4));
    wq2 = wq[16:19];
    build_frame(wq2, exp);
    compare_frame("trunc_frame2", got2, exp);
    check("trunc_len2", 64'(got2[1]), 64'd4);
    check("trunc_pulses", 64'(trunc_cnt), 64'd1);
    check("trunc_with_sof", 64'(trunc_bad), 64'd0);

    // Asynchronous reset while the fifth byte of the three-word frame is presented.
    wq = {32'hFFFFFFFF, 32'h00000000, 32'h80000001};
    push_frame(wq, 1'b0);
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_reset_byte5", {55'd0, m_valid, m_byte}, {55'd0, 1'b1, 8'hFF});
    resetn = 1'b0;
    #1;
    check("mid_rst_m_valid", 64'(m_valid), 64'd0);
    check("mid_rst_s_ready", 64'(s_ready), 64'd1);
    check("mid_rst_m_last",  64'(m_last),  64'd0);
    check("mid_rst_m_byte",  64'(m_byte),  64'd0);
    m_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    wq = {32'h01020304};
    push_frame(wq, 1'b0);
    recv(1'b0, got, cyc);
    exp = {8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
    compare_frame("post_reset", got, exp);

    // Upstream held valid while downstream stalls: nothing accepted until CSUM completes.
    wq = {32'hDEADBEEF, 32'h00C0FFEE};
    push_frame(wq, 1'b0);
    s_valid = 1'b1; s_data = 32'h01020304; s_last = 1'b1;
    up_hs = 0;
    m_ready = 1'b0;
    repeat (10) begin
      if (s_valid && s_ready) up_hs++;
      @(negedge clk);
    end
    check("stall_hold_sof", {55'd0, m_valid, m_byte}, {55'd0, 1'b1, 8'hA5});
    recv(1'b0, got, cyc);
    check("stall_no_upstream", 64'(up_hs), 64'd0);
    build_frame(wq, exp);
    compare_frame("stall_frame", got, exp);
    check("ready_after_csum", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("next_frame_sof", {55'd0, m_valid, m_byte}, {55'd0, 1'b1, 8'hA5});
    recv(1'b0, got, cyc);
    exp = {8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
    compare_frame("stall_next", got, exp);

    // Random frames with upstream gaps and random downstream ready.
    for (int f = 0; f < 20; f++) begin
      wq = {};
      repeat ($urandom_range(1, 16)) wq.push_back($urandom);
      push_frame(wq, 1'b1);
      check("rnd_sof", {55'd0, m_valid, m_byte}, {55'd0, 1'b1, 8'hA5});
      recv(f % 4 != 0, got, cyc);
      build_frame(wq, exp);
      compare_frame("rnd_frame", got, exp);
      if (f % 4 == 0) check("rnd_cycles", 64'(cyc), 64'(3 + wq.size() * 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
